// File: rtl/forwarding_bypass_unit.sv
// Operand bypass network: tracks in-flight writebacks across DEPTH post-EX stages and
// resolves each ID source operand to its youngest producer, flagging load-use hazards.
module forwarding_bypass_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int SEL_W      = $clog2(DEPTH + 2)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_in,
  input  logic                         flush,
  input  logic                         ex_wr_en,
  input  logic [REG_ADDR_W-1:0]        ex_rd,
  input  logic [DATA_W-1:0]            ex_result,
  input  logic                         ex_is_load,
  input  logic [DATA_W-1:0]            mem_load_data,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC*DATA_W-1:0]    rf_data,
  output logic [NUM_SRC*DATA_W-1:0]    fwd_data,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
  output logic                         load_use_stall,
  output logic [15:0]                  stall_count
);

  logic                  valid_reg   [DEPTH];
  logic [REG_ADDR_W-1:0] rd_reg      [DEPTH];
  logic [DATA_W-1:0]     data_reg    [DEPTH];
  logic                  is_load_reg [DEPTH];
  logic [15:0]           stall_count_reg;
  logic [NUM_SRC-1:0]    use_hit;

  // Shift pipeline; a load in entry 0 picks up its memory data on the way to entry 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_reg[k]   <= 1'b0;
        rd_reg[k]      <= '0;
        data_reg[k]    <= '0;
        is_load_reg[k] <= 1'b0;
      end
    end else if (!stall_in) begin
      valid_reg[0]   <= ex_wr_en && (ex_rd != '0) && !flush;
      rd_reg[0]      <= ex_rd;
      data_reg[0]    <= ex_result;
      is_load_reg[0] <= ex_is_load;
      for (int k = 1; k < DEPTH; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        rd_reg[k]    <= rd_reg[k-1];
        if (k == 1 && is_load_reg[0]) begin
          data_reg[k]    <= mem_load_data;
          is_load_reg[k] <= 1'b0;
        end else begin
          data_reg[k]    <= data_reg[k-1];
          is_load_reg[k] <= is_load_reg[k-1];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic [DATA_W-1:0]     rf_val;
    logic [SEL_W-1:0]      sel;
    logic [DATA_W-1:0]     data;

    assign rs     = id_rs[gi*REG_ADDR_W +: REG_ADDR_W];
    assign rf_val = rf_data[gi*DATA_W +: DATA_W];

    // Scan oldest to youngest so later (younger) matches override earlier ones.
    always_comb begin
      sel  = '0;
      data = rf_val;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid_reg[k] && rd_reg[k] == rs) begin
          sel  = SEL_W'(k + 2);
          data = (k == 0 && is_load_reg[0]) ? mem_load_data : data_reg[k];
        end
      end
      if (ex_wr_en && !flush && ex_rd == rs) begin
        sel  = SEL_W'(1);
        data = ex_result;
      end
      if (rs == '0) begin
        sel  = '0;
        data = rf_val;
      end
    end

    assign use_hit[gi]                     = (sel == SEL_W'(1)) && ex_is_load;
    assign fwd_sel[gi*SEL_W +: SEL_W]      = sel;
    assign fwd_data[gi*DATA_W +: DATA_W]   = data;
  end

  assign load_use_stall = |use_hit;

  // Counts hazard cycles even while the pipeline is frozen; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_reg <= '0;
    end else if (load_use_stall && stall_count_reg != 16'hFFFF) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_forwarding_bypass_unit.sv
// Directed bench for forwarding_bypass_unit: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares them against the outputs.
module tb_forwarding_bypass_unit;
  localparam int DATA_W = 32;
  localparam int RW     = 5;
  localparam int NS     = 2;
  localparam int DEPTH  = 3;
  localparam int SEL_W  = $clog2(DEPTH + 2);

  logic                  clk;
  logic                  rst_n;
  logic                  stall_in;
  logic                  flush;
  logic                  ex_wr_en;
  logic [RW-1:0]         ex_rd;
  logic [DATA_W-1:0]     ex_result;
  logic                  ex_is_load;
  logic [DATA_W-1:0]     mem_load_data;
  logic [NS*RW-1:0]      id_rs;
  logic [NS*DATA_W-1:0]  rf_data;
  logic [NS*DATA_W-1:0]  fwd_data;
  logic [NS*SEL_W-1:0]   fwd_sel;
  logic                  load_use_stall;
  logic [15:0]           stall_count;

  forwarding_bypass_unit #(
    .DATA_W(DATA_W), .REG_ADDR_W(RW), .NUM_SRC(NS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .mem_load_data(mem_load_data), .id_rs(id_rs), .rf_data(rf_data),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .load_use_stall(load_use_stall),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // chk bits: 0 sel0, 1 data0, 2 sel1, 3 data1, 4 load_use_stall, 5 stall_count
  typedef struct {
    string       name;
    logic [5:0]  chk;
    logic [31:0] s0, d0, s1, d1, stl, cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk[0]) cmp(e.name, "sel0",  32'(fwd_sel[SEL_W-1:0]), e.s0);
      if (e.chk[1]) cmp(e.name, "data0", fwd_data[DATA_W-1:0], e.d0);
      if (e.chk[2]) cmp(e.name, "sel1",  32'(fwd_sel[2*SEL_W-1:SEL_W]), e.s1);
      if (e.chk[3]) cmp(e.name, "data1", fwd_data[2*DATA_W-1:DATA_W], e.d1);
      if (e.chk[4]) cmp(e.name, "stall", 32'(load_use_stall), e.stl);
      if (e.chk[5]) cmp(e.name, "count", 32'(stall_count), e.cnt);
      $display("txn %-10s sel=%0d/%0d data=%0h/%0h stall=%0b count=%0h", e.name,
               fwd_sel[SEL_W-1:0], fwd_sel[2*SEL_W-1:SEL_W], fwd_data[DATA_W-1:0],
               fwd_data[2*DATA_W-1:DATA_W], load_use_stall, stall_count);
    end
  end

  task automatic expect_v(input string name, input logic [5:0] chk,
                          input logic [31:0] s0, input logic [31:0] d0,
                          input logic [31:0] s1, input logic [31:0] d1,
                          input logic [31:0] stl, input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.chk = chk;
    e.s0 = s0; e.d0 = d0; e.s1 = s1; e.d1 = d1; e.stl = stl; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic wr, input logic [RW-1:0] rd, input logic [31:0] res,
                        input logic ld);
    ex_wr_en = wr; ex_rd = rd; ex_result = res; ex_is_load = ld;
  endtask

  task automatic set_rs(input logic [RW-1:0] r0, input logic [RW-1:0] r1);
    id_rs = {r1, r0};
  endtask

  localparam logic [5:0] ALL = 6'h3F;
  localparam logic [5:0] NOD1 = 6'h37;

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
    set_ex(1'b0, 5'd0, 32'd0, 1'b0);
    mem_load_data = 32'd0;
    set_rs(5'd3, 5'd5);
    rf_data = {32'd11, 32'd22};
    #2;
    expect_v("reset", ALL, 0, 22, 0, 11, 0, 0);
    #10 rst_n = 1'b1;

    // EX bypass then aging through entries 0..2
    step(); set_ex(1'b1, 5'd3, 32'hAAAA, 1'b0);
    expect_v("ex_byp", ALL, 1, 32'hAAAA, 0, 11, 0, 0);
    step(); set_ex(1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("ent0", ALL, 2, 32'hAAAA, 0, 11, 0, 0);
    step(); expect_v("ent1", ALL, 3, 32'hAAAA, 0, 11, 0, 0);
    step(); expect_v("ent2", ALL, 4, 32'hAAAA, 0, 11, 0, 0);
    step(); expect_v("aged_out", ALL, 0, 22, 0, 11, 0, 0);

    // Youngest producer wins; r0 never forwards
    step(); set_ex(1'b1, 5'd7, 32'h1, 1'b0); set_rs(5'd7, 5'd5);
    expect_v("r7_first", ALL, 1, 32'h1, 0, 11, 0, 0);
    step(); set_ex(1'b1, 5'd7, 32'h2, 1'b0);
    expect_v("r7_ex_yng", ALL, 1, 32'h2, 0, 11, 0, 0);
    step(); set_ex(1'b0, 5'd0, 32'd0, 1'b0); set_rs(5'd7, 5'd7);
    expect_v("r7_ent_yng", ALL, 2, 32'h2, 2, 32'h2, 0, 0);
    step(); set_ex(1'b1, 5'd0, 32'hFF, 1'b0); set_rs(5'd0, 5'd7);
    expect_v("r0_ex", ALL, 0, 22, 3, 32'h2, 0, 0);
    step(); set_ex(1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("r0_ent", ALL, 0, 22, 4, 32'h2, 0, 0);

    // Load-use hazard and load data capture
    step(); set_ex(1'b1, 5'd4, 32'hDEAD, 1'b1); set_rs(5'd5, 5'd4);
    expect_v("ld_use", NOD1, 0, 22, 1, 0, 1, 0);
    step(); set_ex(1'b0, 5'd0, 32'd0, 1'b0); mem_load_data = 32'hBEEF;
    expect_v("ld_ent0", ALL, 0, 22, 2, 32'hBEEF, 0, 1);
    step(); mem_load_data = 32'h1234;
    expect_v("ld_capt", ALL, 0, 22, 3, 32'hBEEF, 0, 1);

    // Freeze and flush
    step(); set_ex(1'b1, 5'd9, 32'h9999, 1'b0); set_rs(5'd9, 5'd4);
    expect_v("r9_ex", ALL, 1, 32'h9999, 4, 32'hBEEF, 0, 1);
    step(); set_ex(1'b0, 5'd0, 32'd0, 1'b0); stall_in = 1'b1;
    expect_v("frz1", ALL, 2, 32'h9999, 0, 11, 0, 1);
    step(); expect_v("frz2", ALL, 2, 32'h9999, 0, 11, 0, 1);
    step(); expect_v("frz3", ALL, 2, 32'h9999, 0, 11, 0, 1);
    step(); stall_in = 1'b0; flush = 1'b1; set_ex(1'b1, 5'd9, 32'h5555, 1'b0);
    expect_v("flush_ex", ALL, 2, 32'h9999, 0, 11, 0, 1);
    step(); flush = 1'b0; set_ex(1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("flush_bub", ALL, 3, 32'h9999, 0, 11, 0, 1);
    step(); stall_in = 1'b1; flush = 1'b1; set_ex(1'b1, 5'd9, 32'h7777, 1'b0);
    expect_v("stl_flush", ALL, 4, 32'h9999, 0, 11, 0, 1);
    step(); flush = 1'b0; set_ex(1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("stl_held", ALL, 4, 32'h9999, 0, 11, 0, 1);
    step(); stall_in = 1'b0;
    expect_v("unfreeze", ALL, 4, 32'h9999, 0, 11, 0, 1);
    step(); expect_v("r9_gone", ALL, 0, 22, 0, 11, 0, 1);

    // Saturating stall counter, then async reset mid-cycle
    step(); set_ex(1'b1, 5'd4, 32'hDEAD, 1'b1); set_rs(5'd5, 5'd4);
    expect_v("sat_start", NOD1, 0, 22, 1, 0, 1, 1);
    repeat (65540) @(posedge clk);
    #1;
    expect_v("sat_end", NOD1, 0, 22, 1, 0, 1, 32'hFFFF);
    step(); set_ex(1'b0, 5'd0, 32'd0, 1'b0);
    expect_v("sat_hold", ALL, 0, 22, 2, 32'h1234, 0, 32'hFFFF);
    step(); #1 rst_n = 1'b0;
    expect_v("mid_reset", ALL, 0, 22, 0, 11, 0, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    step(); expect_v("post_reset", ALL, 0, 22, 0, 11, 0, 0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/forwarding_bypass_unit.md
Name: forwarding_bypass_unit

Overview:
- Parametrised bypass network for the 5-stage MIPS pipeline; supersedes the fixed 3-input, single-operand forwarding mux.
- Tracks in-flight destination registers and results across DEPTH post-EX stages in an internal shift pipeline.
- Resolves NUM_SRC source operands for the instruction in ID, using youngest-producer priority.
- Raises a load-use stall and keeps a saturating stall-cycle counter.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 5, register address width
NUM_SRC, 2, source operands resolved per cycle
DEPTH, 3, tracked post-EX stages (entry 0 = MEM, entry DEPTH-1 = oldest); minimum 1
SEL_W, $clog2(DEPTH+2), width of each select code (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_in  in  1  pipeline freeze: hold all state
flush  in  1  replace EX-stage instruction with bubble on shift
ex_wr_en  in  1  EX instruction writes a register
ex_rd  in  REG_ADDR_W  EX destination register
ex_result  in  DATA_W  EX ALU result
ex_is_load  in  1  EX instruction is a load
mem_load_data  in  DATA_W  load data for entry 0, valid this cycle
id_rs  in  NUM_SRC*REG_ADDR_W  ID source register numbers, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
rf_data  in  NUM_SRC*DATA_W  register-file read data per operand
fwd_data  out  NUM_SRC*DATA_W  resolved operand values
fwd_sel  out  NUM_SRC*SEL_W  source code per operand: 0=regfile, 1=EX, k+2=entry k
load_use_stall  out  1  ID must stall one cycle
stall_count  out  16  saturating count of cycles with load_use_stall=1

Behaviour:
- Entry k holds {valid, rd, data, is_load}.
- Reset (async, rst_n=0):
  - all entries valid=0, rd=0, data=0, is_load=0; stall_count=0.
  - Outputs therefore read fwd_sel=0, fwd_data=rf_data, load_use_stall=0.
- Shift on rising clk when stall_in=0:
  - entry0 <= {ex_wr_en & (ex_rd!=0) & ~flush, ex_rd, ex_result, ex_is_load}.
  - entry1 <= entry0, except data <= mem_load_data and is_load <= 0 when entry0.is_load=1.
  - entry k (k>=2) <= entry k-1.
- stall_in=1: all entries hold. stall_in takes priority over flush; flush is ignored while stalled.
- Operand resolution, combinational from registered state plus EX inputs, per operand i:
  - id_rs[i]==0 always selects regfile (sel=0).
  - Otherwise the youngest match wins: EX (ex_wr_en & ~flush & ex_rd==rs) > entry0 > entry1 > ... > entry DEPTH-1.
  - No match selects regfile.
- Data per selected source:
  - EX: ex_result.
  - entry0 with is_load=1: mem_load_data.
  - All other entries: stored data.
  - Regfile: rf_data[i].
- load_use_stall = 1 when any operand selects EX and ex_is_load=1. In that case fwd_sel still reports 1, and fwd_data is don't-care.
- Multiple matching entries (same rd written repeatedly): youngest only.
- stall_count:
  - increments on each rising clk with load_use_stall=1, independent of stall_in.
  - saturates at 16'hFFFF, no wrap.
  - cleared only by reset.
- Reset asserted mid-operation: all entries are invalidated immediately (async). No forwarding occurs until new writes enter.
- Latency: a result is forwardable from EX in the same cycle, and from entry k for k+1 cycles after that.
- Fully synchronous outputs aside from the combinational select path; no combinational path from rst_n to data.

Test Plan:
- Reset: rst_n=0 with id_rs={5,3}, rf_data={11,22} -> fwd_sel={0,0}, fwd_data={11,22}, stall_count=0, load_use_stall=0.
- EX bypass: ex_wr_en=1, ex_rd=3, ex_result=0xAAAA, id_rs[0]=3 -> fwd_sel[0]=1, fwd_data[0]=0xAAAA. Next cycle (ex_wr_en=0) -> fwd_sel[0]=2, data 0xAAAA. After DEPTH+1 total cycles -> fwd_sel[0]=0.
- Youngest wins: write r7=0x1 then r7=0x2 on consecutive cycles, then query r7 -> sel=2, data 0x2. Also write r0=0xFF, query r0 -> sel=0, rf_data.
- Load-use:
  - ex_is_load=1, ex_rd=4, id_rs[1]=4 -> load_use_stall=1, stall_count 0->1.
  - Next cycle with mem_load_data=0xBEEF -> sel=2, data 0xBEEF.
  - Cycle after -> sel=3, data 0xBEEF (captured).
- stall_in/flush:
  - stall_in=1 for 3 cycles with r9 in entry0 -> r9 stays sel=2.
  - flush=1 with ex_wr_en=1, ex_rd=9 -> no EX match; no entry created.
  - stall_in=1 & flush=1 -> entries held.
- Saturation: hold load_use_stall=1 for 65540 cycles -> stall_count=16'hFFFF. Async reset mid-run -> count 0 and all entries invalid within the same cycle.
